// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pkg
//  Description : Timing constants for 800x600@60 Hz (40 MHz pixel clock) and
//                the colour-bar table used by the optional test pattern.
//  Revision    : 1.0  initial release
// ============================================================================
package vga_pkg;

    // Horizontal timing, in pixel clocks
    localparam logic [10:0] HOR_PIXELS     = 11'd800;
    localparam logic [10:0] HOR_TOTAL      = 11'd1056;
    localparam logic [10:0] HOR_SYNC_START = 11'd840;
    localparam logic [10:0] HOR_SYNC_END   = 11'd968;

    // Vertical timing, in lines
    localparam logic [10:0] VER_PIXELS     = 11'd600;
    localparam logic [10:0] VER_TOTAL      = 11'd628;
    localparam logic [10:0] VER_SYNC_START = 11'd601;
    localparam logic [10:0] VER_SYNC_END   = 11'd605;

    // Colour-bar test pattern: 8 bars of 100 pixels
    localparam logic [6:0]  BAR_WIDTH      = 7'd100;
    localparam logic [11:0] BAR_COLOURS [8] = '{
        12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
        12'hF0F, 12'hF00, 12'h00F, 12'h000
    };

endpackage
`default_nettype wire

// File: rtl/vga_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_if
//  Description : Video stream bundle passed between pipeline stages.
//                'out' modport: producer side, 'in' modport: consumer side.
//                hcount[10:0], hsync, hblnk, vcount[10:0], vsync, vblnk,
//                rgb[11:0] (38 bits total).
//  Revision    : 1.0  initial release
// ============================================================================
interface vga_if;

    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [11:0] rgb;

    modport out (
        output hcount, hsync, hblnk, vcount, vsync, vblnk, rgb
    );

    modport in (
        input  hcount, hsync, hblnk, vcount, vsync, vblnk, rgb
    );

endinterface
`default_nettype wire

// File: rtl/vga_counter.sv
`default_nettype none
// ============================================================================
//  Module      : vga_counter
//  Description : Modulo-MODULUS up counter with enable.
//  Ports       : clk   - clock
//                rst   - asynchronous active-high reset (count -> 0)
//                en    - advance the count this cycle
//                count - current count, 0..MODULUS-1 (flop output)
//                wrap  - en is high and count is at MODULUS-1, i.e. the
//                        count returns to 0 on the next edge
//  Revision    : 1.0  initial release
// ============================================================================
module vga_counter #(
    parameter int WIDTH   = 11,
    parameter int MODULUS = 1056
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] c_last = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_count;

    assign wrap  = en && (r_count == c_last);
    assign count = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= wrap ? '0 : r_count + WIDTH'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing
//  Description : Free-running 800x600@60 Hz VGA timing generator. Produces
//                hcount/vcount with cycle-aligned sync and blanking, a
//                frame-start pulse and a completed-frame counter.
//  Ports       : clk         - 40 MHz pixel clock
//                rst         - asynchronous active-high reset
//                out         - vga_if.out stream (all fields registered)
//                frame_start - one-cycle pulse while out presents (0,0)
//                frame_cnt   - 8-bit completed-frame counter, wraps
//  Macro       : VGA_TEST_PATTERN_EN - when defined, rgb carries 8 vertical
//                colour bars in the active area; otherwise rgb is 0.
//  Revision    : 1.0  initial release
// ============================================================================
module vga_timing
    import vga_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    vga_if.out         out,
    output logic       frame_start,
    output logic [7:0] frame_cnt
);

    logic [10:0] w_hc;
    logic [10:0] w_vc;
    logic        w_h_wrap;
    logic        w_v_wrap;
    logic [10:0] w_hc_nxt;
    logic [10:0] w_vc_nxt;

    logic        r_hsync;
    logic        r_hblnk;
    logic        r_vsync;
    logic        r_vblnk;
    logic        r_frame_start;
    logic [7:0]  r_frame_cnt;

    vga_counter #(
        .WIDTH   (11),
        .MODULUS (int'(HOR_TOTAL))
    ) u_hcnt (
        .clk   (clk),
        .rst   (rst),
        .en    (1'b1),
        .count (w_hc),
        .wrap  (w_h_wrap)
    );

    // Vertical counter advances only on the last pixel of each line, so its
    // wrap flag marks the final pixel of the frame.
    vga_counter #(
        .WIDTH   (11),
        .MODULUS (int'(VER_TOTAL))
    ) u_vcnt (
        .clk   (clk),
        .rst   (rst),
        .en    (w_h_wrap),
        .count (w_vc),
        .wrap  (w_v_wrap)
    );

    // The values the counters will hold after the next edge. Decoding these
    // keeps the registered sync/blank bits aligned with the counts.
    assign w_hc_nxt = w_h_wrap ? 11'd0 : w_hc + 11'd1;
    assign w_vc_nxt = w_v_wrap ? 11'd0 : (w_h_wrap ? w_vc + 11'd1 : w_vc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hsync       <= 1'b0;
            r_hblnk       <= 1'b0;
            r_vsync       <= 1'b0;
            r_vblnk       <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_cnt   <= 8'd0;
        end else begin
            r_hblnk       <= (w_hc_nxt >= HOR_PIXELS);
            r_hsync       <= (w_hc_nxt >= HOR_SYNC_START) && (w_hc_nxt < HOR_SYNC_END);
            r_vblnk       <= (w_vc_nxt >= VER_PIXELS);
            r_vsync       <= (w_vc_nxt >= VER_SYNC_START) && (w_vc_nxt < VER_SYNC_END);
            // Out of reset the counters start at (0,0) without a wrap, so the
            // partial first frame never raises frame_start.
            r_frame_start <= w_v_wrap;
            if (w_v_wrap) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    assign out.hcount  = w_hc;
    assign out.vcount  = w_vc;
    assign out.hsync   = r_hsync;
    assign out.hblnk   = r_hblnk;
    assign out.vsync   = r_vsync;
    assign out.vblnk   = r_vblnk;
    assign frame_start = r_frame_start;
    assign frame_cnt   = r_frame_cnt;

`ifdef VGA_TEST_PATTERN_EN
    // Bar index without a divider: r_bar_sub counts 0..99 across each bar,
    // r_bar_idx steps once per bar; both track hc and restart on its wrap.
    logic [6:0]  r_bar_sub;
    logic [2:0]  r_bar_idx;
    logic [6:0]  w_bar_sub_nxt;
    logic [2:0]  w_bar_idx_nxt;
    logic [11:0] r_rgb;

    always_comb begin
        w_bar_sub_nxt = r_bar_sub + 7'd1;
        w_bar_idx_nxt = r_bar_idx;
        if (w_h_wrap) begin
            w_bar_sub_nxt = 7'd0;
            w_bar_idx_nxt = 3'd0;
        end else if (r_bar_sub == (BAR_WIDTH - 7'd1)) begin
            w_bar_sub_nxt = 7'd0;
            w_bar_idx_nxt = r_bar_idx + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bar_sub <= 7'd0;
            r_bar_idx <= 3'd0;
            r_rgb     <= 12'h000;
        end else begin
            r_bar_sub <= w_bar_sub_nxt;
            r_bar_idx <= w_bar_idx_nxt;
            r_rgb     <= ((w_hc_nxt < HOR_PIXELS) && (w_vc_nxt < VER_PIXELS))
                         ? BAR_COLOURS[w_bar_idx_nxt] : 12'h000;
        end
    end

    assign out.rgb = r_rgb;
`else
    assign out.rgb = 12'h000;
`endif

endmodule
`default_nettype wire

// File: doc/vga_timing.md
# vga_timing

Free-running VGA timing generator: the producer end of the `vga_if` stream that the drawing stages consume. It drives `hcount`/`vcount`, sync and blanking for 800x600@60 Hz at a 40 MHz pixel clock, and provides a frame-start pulse and frame counter. Optionally it drives a colour-bar test pattern on `rgb`. It is the first stage of every video pipeline, ahead of background and menu drawing.

## Interface
Parameters: none. All timing constants are taken from `vga_pkg`.

Ports:
- `clk`  in  1  pixel clock, 40 MHz
- `rst`  in  1  reset; asynchronous, active-high
- `out`  `vga_if.out`  38 total  `hcount[10:0]`, `hsync`, `hblnk`, `vcount[10:0]`, `vsync`, `vblnk`, `rgb[11:0]`
- `frame_start`  out  1  one-cycle pulse while `out` presents pixel (0,0)
- `frame_cnt`  out  8  completed-frame counter, wraps

## Operation
- **Horizontal counter** `hc`:
  - 0..`HOR_TOTAL`-1 (0..1055).
  - Increments every cycle; wraps to 0 after 1055.
- **Vertical counter** `vc`:
  - 0..`VER_TOTAL`-1 (0..627).
  - Increments only when `hc` wraps; wraps to 0 after 627.
- **Decodes**, all evaluated on the same count values presented on `out`:
  - `hblnk` = `hc` ≥ `HOR_PIXELS` (800).
  - `hsync` = `HOR_SYNC_START` ≤ `hc` < `HOR_SYNC_END` (840..967), active-high.
  - `vblnk` = `vc` ≥ `VER_PIXELS` (600).
  - `vsync` = `VER_SYNC_START` ≤ `vc` < `VER_SYNC_END` (601..604), active-high.
- **frame_start**:
  - High exactly when `out` moves from (1055,627) to (0,0).
  - Low in reset and on the first cycle after reset release.
- **frame_cnt**: increments on the same edge that raises `frame_start`; wraps from 255 to 0.
- **rgb**: 0 when the macro is absent (see Configuration).
- **Reset**: while `rst` is high, all outputs are 0: `hcount`, `vcount`, `hsync`, `vsync`, `hblnk`, `vblnk`, `rgb`, `frame_start`, `frame_cnt`.
- **Reset mid-frame**:
  - Asserting `rst` clears everything asynchronously.
  - After release, counting restarts from (0,0) with no `frame_start` for that partial start.

## Timing
- Every output is a flop output; there are no combinational paths to ports.
- All of `out`'s fields are cycle-aligned: sync, blank and `rgb` describe the `hcount`/`vcount` presented in the same cycle. This requires next-state decoding from `hc_nxt`/`vc_nxt`.
- First rising edge after `rst` deasserts: `out` = (1,0).
- Line period: 1056 cycles; frame period: 663168 cycles.
- Sync widths:
  - `hsync` high for 128 cycles per line.
  - `vsync` high for 4 lines, i.e. 4224 cycles.
- `vsync` edges coincide with `hc` = 0.

## Configuration
- Macro: `VGA_TEST_PATTERN_EN`.
- **Defined**: in the active area, `rgb` = `BAR_COLOURS[hc/100]`, giving 8 vertical bars of 100 px each. Colours: white, yellow, cyan, green, magenta, red, blue, black (12'hFFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000). `rgb` = 0 in blanking.
- **Undefined**: `rgb` is constant 0 and the bar logic is not synthesised.
- Timing, latency and all other outputs are identical in both builds.

## Structure
- `vga_pkg` holds:
  - `HOR_PIXELS`, `HOR_TOTAL`, `HOR_SYNC_START`, `HOR_SYNC_END`.
  - `VER_PIXELS`, `VER_TOTAL`, `VER_SYNC_START`, `VER_SYNC_END`.
  - `BAR_WIDTH` (100).
  - `BAR_COLOURS`, a `logic [11:0]` array of 8.
- No division in RTL: the bar index comes from a 0..99 sub-counter plus a 3-bit bar counter, both reset when `hc` wraps.
- One sub-module: `vga_counter`, a parameterised modulo counter with `clk`, `rst`, `en`, `count`, `wrap`. It is instantiated twice, for horizontal and vertical.

## Test plan
- **Reset**: hold `rst` 10 cycles mid-frame → all outputs 0 throughout; first post-release cycle `hcount`=1, `vcount`=0, `frame_start`=0.
- **Line timing**: run 2 lines → `hblnk` rises at `hcount`=800; `hsync` high exactly for `hcount` 840..967; `hcount` wraps 1055→0 with `vcount` incrementing on the same cycle.
- **Frame timing**: run 1 frame → `vblnk` high for `vcount` 600..627; `vsync` high for 4224 cycles starting at `vcount`=601, `hcount`=0; `frame_start` one cycle at (0,0); `frame_cnt` 0→1.
- **Counter wrap**: run 256 frames → `frame_cnt` returns to 0 and exactly 256 `frame_start` pulses are seen.
- **Pattern** (`VGA_TEST_PATTERN_EN` defined): line 10 → `rgb`=FFF at `hcount` 0 and 99, FF0 at 100, 000 at 799, 0 at 800..1055.
- **Without macro**: `rgb`=0 for all cycles over one full frame; sync/blank identical to the defined build.
